// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and halt/drain control for a 5-stage pipeline.
// Define PIPE_FORWARDING_EN to enable EX operand forwarding; otherwise every RAW hazard stalls.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wb,
    input  logic              id_load,
    input  logic              id_halt,
    input  logic              ex_branch_taken,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              bubble_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wb;
    } rec_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state_q, state_d;
    rec_t             ex_q, mem_q, ex_d;
    logic             ex_load_q, wb_v_q;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run, hazard, stall, issue, ex_a, ex_b, mem_a, mem_b;

    // Only the valid bit of the WB record matters: the regfile write lands before ID reads.
    function automatic logic hit(rec_t r, logic en, logic [REG_AW-1:0] src);
        return en & r.valid & r.wb & (r.rd != '0) & (r.rd == src);
    endfunction

    always_comb begin
        ex_a  = hit(ex_q, id_use_rs, id_rs);
        ex_b  = hit(ex_q, id_use_rt, id_rt);
        mem_a = hit(mem_q, id_use_rs, id_rs);
        mem_b = hit(mem_q, id_use_rt, id_rt);
        run   = state_q == RUN;
`ifdef PIPE_FORWARDING_EN
        hazard = ex_load_q & (ex_a | ex_b);
        sel_a  = ex_a ? 2'b10 : mem_a ? 2'b01 : 2'b00;
        sel_b  = ex_b ? 2'b10 : mem_b ? 2'b01 : 2'b00;
`else
        hazard = ex_a | ex_b | mem_a | mem_b;
        sel_a  = 2'b00;
        sel_b  = 2'b00;
`endif
        stall        = run & id_valid & hazard & ~ex_branch_taken;
        issue        = run & id_valid & ~hazard & ~ex_branch_taken;
        ex_d         = issue ? {1'b1, id_rd, id_wb} : '0;
        fwd_a_d      = issue ? sel_a : 2'b00;
        fwd_b_d      = issue ? sel_b : 2'b00;
        state_d      = (issue & id_halt) ? DRAIN :
                       ((state_q == DRAIN) & ~(ex_q.valid | mem_q.valid | wb_v_q)) ? HALTED : state_q;
        cnt_d        = (stall & !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        stall_if_id  = ~reset & (stall | ~run);
        flush_if_id  = ~reset & run & ex_branch_taken;
        bubble_id_ex = ~reset & (stall | (run & ex_branch_taken) | (state_q == DRAIN));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            ex_q      <= '0;
            mem_q     <= '0;
            ex_load_q <= 1'b0;
            wb_v_q    <= 1'b0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ex_q      <= ex_d;
            mem_q     <= ex_q;
            ex_load_q <= issue & id_load;
            wb_v_q    <= mem_q.valid;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign halted      = state_q == HALTED;
    assign stall_count = cnt_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline. It drives hold/flush controls for the IF/ID and ID/EX registers and the operand-forwarding selects for the EX stage.
- It keeps a shadow scoreboard of destination registers in flight through EX, MEM and WB, built from decode information. It also handles load-use stalls, taken-branch flushes and the halt/drain sequence.
- It sits beside the inter-stage registers (including mem_wb_reg) and is fed from the ID and EX stages.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_wb  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- id_halt  in  1  ID instruction is HALT.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- stall_if_id  out  1  PC and IF/ID hold (combinational).
- flush_if_id  out  1  IF/ID loads a bubble (combinational).
- bubble_id_ex  out  1  ID/EX loads a bubble (combinational).
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM (registered).
- fwd_b  out  2  EX operand B select, same encoding (registered).
- halted  out  1  pipeline fully drained after HALT.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset values: scoreboard all invalid, state RUN, fwd_a = fwd_b = 00, halted = 0, stall_count = 0. Combinational outputs are 0 while reset is high.
- Scoreboard: three stage records (ex, mem, wb), each holding {valid, rd, wb, load}. Every non-reset posedge:
  - wb <= mem; mem <= ex.
  - ex <= ID info if the instruction issues, else a bubble (valid = 0).
  - A record is a writer if valid & wb & rd != 0. Register 0 never creates a hazard.
- Issue condition: id_valid & !stall & !ex_branch_taken & state == RUN.
- Hazard match: a writer record whose rd equals id_rs (when id_use_rs) or id_rt (when id_use_rt).
- Stall (FORWARDING_EN defined): id_valid & ex record is a load writer & hazard match.
  - Gives exactly 1 stall cycle per load-use pair.
- Stall outputs: stall => stall_if_id = 1, bubble_id_ex = 1.
- Branch taken: flush_if_id = 1 and bubble_id_ex = 1 in the same cycle; stall_if_id is forced to 0. Branch has priority over stall.
- Forwarding, registered at issue, valid during the instruction's EX cycle:
  - 10 if the ex record matches (it will be in EX/MEM).
  - else 01 if the mem record matches (it will be in MEM/WB).
  - else 00.
  - Nearest-stage match wins. On a non-issue cycle, both selects register 00.
- State machine:
  - RUN -> DRAIN when the HALT instruction issues. A HALT in ID during a taken-branch cycle is discarded.
  - DRAIN: stall_if_id = 1 and bubble_id_ex = 1 every cycle; no issue.
  - DRAIN -> HALTED when ex, mem and wb records are all invalid.
  - HALTED: halted = 1, stall_if_id = 1; only reset exits this state.
- stall_count increments on each cycle with stall = 1 in RUN. It saturates at all-ones; no wrap.
- Register-file write occurs in the first half of WB, so the wb record never causes a stall.
- Reset asserted mid-stall or mid-drain returns every output to its reset value on the next edge.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- Defined: forwarding selects active as above; only load-use hazards stall.
- Undefined: fwd_a/fwd_b are tied to 00. Any hazard match against the ex or mem record stalls, repeating until the writer reaches WB (up to 2 cycles).

Test Plan:
- Reset: hold reset 2 cycles, then release -> all outputs 0, state RUN, stall_count = 0.
- Forwarding (PIPE_FORWARDING_EN): issue ADD rd=3, then SUB rs=3 -> no stall; SUB's EX cycle has fwd_a = 10. A third instruction with rt=3 -> fwd_b = 01.
- Load-use (PIPE_FORWARDING_EN): issue LW rd=5, then ADD rs=5 -> stall_if_id = 1 and bubble_id_ex = 1 for exactly 1 cycle. ADD then issues with fwd_a = 01; stall_count = 1.
- Register 0 / no forwarding: ADD rd=0 then a reader of r0 -> no stall. Without the macro, ADD rd=4 then a reader of r4 -> 2 stall cycles, fwd = 00.
- Branch priority: ex_branch_taken = 1 while a load-use stall is pending -> flush_if_id = 1, bubble_id_ex = 1, stall_if_id = 0, stall_count unchanged.
- Halt: issue LW, ADD, HALT back-to-back -> DRAIN. halted rises once the last real instruction leaves WB; a reset pulse then clears halted.
